aidan_mcnay_stride_counter: RTL and testbench

AIDAN_MCNAY_STRIDE_COUNTER -- requirements
Module: aidan_mcnay_stride_counter

---
 rtl/aidan_mcnay_stride_counter.sv | 77 +++++++
 tb/tb_aidan_mcnay_stride_counter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/aidan_mcnay_stride_counter.sv
// rtl/aidan_mcnay_stride_counter.sv - loadable up/down stride counter with wrap or saturate at a bound
module aidan_mcnay_stride_counter #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [nbits-1:0] in_num,
  input  logic             latch_val,
  input  logic             en,
  input  logic [nbits-1:0] step,
  input  logic [nbits-1:0] limit,
  input  logic             down,
  input  logic             sat,
  output logic [nbits-1:0] out_num,
  output logic             at_limit,
  output logic             wrapped
);

  logic [nbits-1:0] count_q;
  logic [nbits-1:0] count_d;
  logic             wrapped_q;
  logic             wrapped_d;

  // One extra bit keeps the carry of an add and the borrow of a subtract.
  logic [nbits:0]   sum_ext;
  logic [nbits:0]   diff_ext;
  logic [nbits:0]   limit_ext;
  logic             cross_up;
  logic             cross_down;
  logic             crossing;
  logic [nbits-1:0] candidate;

  // Stride candidate and bound-crossing detection for the current direction.
  always_comb begin
    limit_ext  = {1'b0, limit};
    sum_ext    = {1'b0, count_q} + {1'b0, step};
    diff_ext   = {1'b0, count_q} - {1'b0, step};
    cross_up   = (sum_ext > limit_ext);
    cross_down = diff_ext[nbits] || (diff_ext[nbits-1:0] < limit);
    crossing   = down ? cross_down : cross_up;
    candidate  = down ? diff_ext[nbits-1:0] : sum_ext[nbits-1:0];
  end

  // Next-state selection: load beats step, step beats hold.
  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (latch_val) begin
      count_d = in_num;
    end else if (en) begin
      if (!crossing) begin
        count_d = candidate;
      end else if (sat) begin
        count_d = limit;
      end else begin
        count_d   = in_num;
        wrapped_d = 1'b1;
      end
    end
  end

  // State registers; reset overrides every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign out_num  = count_q;
  assign wrapped  = wrapped_q;
  assign at_limit = (count_q == limit);

endmodule

// File: tb/tb_aidan_mcnay_stride_counter.sv
// tb/tb_aidan_mcnay_stride_counter.sv - directed self-checking bench for the stride counter
module tb_aidan_mcnay_stride_counter;

  logic       clk;
  logic       rst;
  logic [7:0] in_num;
  logic       latch_val;
  logic       en;
  logic [7:0] step;
  logic [7:0] limit;
  logic       down;
  logic       sat;
  logic [7:0] out_num;
  logic       at_limit;
  logic       wrapped;

  int vectors;
  int miscompares;

  aidan_mcnay_stride_counter #(.nbits(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_num    (in_num),
    .latch_val (latch_val),
    .en        (en),
    .step      (step),
    .limit     (limit),
    .down      (down),
    .sat       (sat),
    .out_num   (out_num),
    .at_limit  (at_limit),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] e_out, input logic e_wrap);
    chk({tag, ".out"}, {24'd0, out_num}, {24'd0, e_out});
    chk({tag, ".wrap"}, {31'd0, wrapped}, {31'd0, e_wrap});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // reset priority over load and enable
    rst = 1'b1; latch_val = 1'b1; en = 1'b1; in_num = 8'd7;
    step = 8'd1; limit = 8'd5; down = 1'b0; sat = 1'b0;
    tick();
    chk_state("rst", 8'd0, 1'b0);
    chk("rst.at_limit_ne", {31'd0, at_limit}, 32'd0);
    limit = 8'd0;
    #1;
    chk("rst.at_limit_eq", {31'd0, at_limit}, 32'd1);

    // up-count with wrap
    rst = 1'b0; latch_val = 1'b1; en = 1'b0; in_num = 8'd5;
    tick();
    chk_state("up.load", 8'd5, 1'b0);
    latch_val = 1'b0; en = 1'b1; step = 8'd3; limit = 8'd20;
    tick(); chk_state("up.8", 8'd8, 1'b0);
    tick(); chk_state("up.11", 8'd11, 1'b0);
    tick(); chk_state("up.14", 8'd14, 1'b0);
    tick(); chk_state("up.17", 8'd17, 1'b0);
    tick(); chk_state("up.20", 8'd20, 1'b0);
    chk("up.at_limit", {31'd0, at_limit}, 32'd1);
    tick(); chk_state("up.wrap", 8'd5, 1'b1);
    tick(); chk_state("up.after", 8'd8, 1'b0);

    // saturation with the same stimulus
    latch_val = 1'b1; en = 1'b0; sat = 1'b1;
    tick(); chk_state("sat.load", 8'd5, 1'b0);
    latch_val = 1'b0; en = 1'b1;
    tick(); chk_state("sat.8", 8'd8, 1'b0);
    tick(); chk_state("sat.11", 8'd11, 1'b0);
    tick(); chk_state("sat.14", 8'd14, 1'b0);
    tick(); chk_state("sat.17", 8'd17, 1'b0);
    tick(); chk_state("sat.20", 8'd20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_state("sat.hold", 8'd20, 1'b0);
      chk("sat.at_limit", {31'd0, at_limit}, 32'd1);
    end

    // carry out of the top bit counts as a crossing
    latch_val = 1'b1; en = 1'b0; in_num = 8'd250; sat = 1'b0;
    tick(); chk_state("carry.load", 8'd250, 1'b0);
    latch_val = 1'b0; en = 1'b1; in_num = 8'd3; step = 8'd10; limit = 8'd255;
    tick(); chk_state("carry.wrap", 8'd3, 1'b1);
    latch_val = 1'b1; en = 1'b0; in_num = 8'd250; sat = 1'b1;
    tick(); chk_state("carry.load2", 8'd250, 1'b0);
    latch_val = 1'b0; en = 1'b1;
    tick(); chk_state("carry.sat", 8'd255, 1'b0);
    chk("carry.at_limit", {31'd0, at_limit}, 32'd1);

    // down-count with borrow
    latch_val = 1'b1; en = 1'b0; in_num = 8'd10; sat = 1'b0;
    tick(); chk_state("dn.load", 8'd10, 1'b0);
    latch_val = 1'b0; en = 1'b1; step = 8'd4; limit = 8'd1; down = 1'b1;
    tick(); chk_state("dn.6", 8'd6, 1'b0);
    tick(); chk_state("dn.2", 8'd2, 1'b0);
    tick(); chk_state("dn.borrow", 8'd10, 1'b1);
    step = 8'd12;
    tick(); chk_state("dn.borrow12", 8'd10, 1'b1);
    en = 1'b0;
    tick(); chk_state("dn.idle", 8'd10, 1'b0);

    // down to exactly the floor is not a crossing
    step = 8'd9; en = 1'b1;
    tick(); chk_state("dn.floor", 8'd1, 1'b0);
    chk("dn.at_limit", {31'd0, at_limit}, 32'd1);

    // simultaneous load and enable, hold, mid-count reset
    latch_val = 1'b1; en = 1'b1; in_num = 8'd9; down = 1'b0; step = 8'd3; limit = 8'd100;
    tick(); chk_state("sim.load", 8'd9, 1'b0);
    latch_val = 1'b0; en = 1'b0;
    tick(); chk_state("sim.hold1", 8'd9, 1'b0);
    tick(); chk_state("sim.hold2", 8'd9, 1'b0);
    en = 1'b1;
    tick(); chk_state("sim.12", 8'd12, 1'b0);
    rst = 1'b1;
    tick(); chk_state("sim.rst", 8'd0, 1'b0);
    rst = 1'b0;
    tick(); chk_state("sim.3", 8'd3, 1'b0);
    tick(); chk_state("sim.6", 8'd6, 1'b0);

    // zero stride holds the count
    step = 8'd0;
    tick(); chk_state("step0", 8'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
